pong_engine: RTL and testbench

//  Parametrised ping-pong game core: ball on an N_LEDS LED strip, two paddle

---
 rtl/pong_engine.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_pong_engine.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pong_engine.sv
// pong_engine: ping-pong game core driving a one-hot ball on an LED strip, with a target-score menu and rally/point/over FSM.
// Latency: button/paddle edges act on the 3rd clk edge after the input rises; the ball steps once per prescaler tick.
// Backpressure: none; outputs are registered levels that the display mux samples whenever it likes.
//
// Ports:
//   clk, resetn                   clock, asynchronous active-low reset
//   btn_start                     start game from MENU (synchronised level)
//   btn_inc, btn_dec              MENU target +1 / -1 (synchronised rising edge)
//   btn_clr                       leave OVER/ERROR (synchronised rising edge)
//   paddle_l, paddle_r            player swings (synchronised rising edge)
//   led[N_LEDS-1:0]               one-hot ball position, zero outside RALLY/POINT
//   score_l, score_r, target      8-bit scores and winning score
//   state[2:0]                    0 MENU, 1 RALLY, 2 POINT, 3 OVER, 4 ERROR
//   winner[1:0]                   01 right, 10 left, 00 none
//
// Optional feature macro: PONG_SPEEDUP_EN -- each valid return raises a 0..3 speed
// level that halves the step period per level; the level drops to 0 on any state change.
module pong_engine #(
    parameter int N_LEDS      = 16,
    parameter int TICK_DIV    = 10_000_000,
    parameter int HIT_WIN     = 1,
    parameter int DEF_TARGET  = 5,
    parameter int MAX_TARGET  = 20,
    parameter int PAUSE_TICKS = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              btn_start,
    input  logic              btn_inc,
    input  logic              btn_dec,
    input  logic              btn_clr,
    input  logic              paddle_l,
    input  logic              paddle_r,
    output logic [N_LEDS-1:0] led,
    output logic [7:0]        score_l,
    output logic [7:0]        score_r,
    output logic [7:0]        target,
    output logic [2:0]        state,
    output logic [1:0]        winner
);

    localparam int PW  = $clog2(N_LEDS);
    localparam int CW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PSW = (PAUSE_TICKS > 1) ? $clog2(PAUSE_TICKS) : 1;

    localparam logic [PW-1:0]  POS_MID      = PW'(N_LEDS / 2);
    localparam logic [PW-1:0]  POS_END_L    = PW'(N_LEDS - 1);
    localparam logic [PW-1:0]  POS_HIT_R_HI = PW'(HIT_WIN);
    localparam logic [PW-1:0]  POS_HIT_L_LO = PW'(N_LEDS - 1 - HIT_WIN);
    localparam logic [PW-1:0]  POS_HIT_L_HI = PW'(N_LEDS - 2);
    localparam logic [PSW-1:0] PAUSE_LAST   = PSW'(PAUSE_TICKS - 1);
    localparam logic [7:0]     TGT_DEF      = 8'(DEF_TARGET);
    localparam logic [7:0]     TGT_MAX      = 8'(MAX_TARGET);

    // dir = 1 moves toward the left end (increasing index)
    localparam logic DIR_L = 1'b1;
    localparam logic DIR_R = 1'b0;

    typedef enum logic [2:0] {
        ST_MENU  = 3'd0,
        ST_RALLY = 3'd1,
        ST_POINT = 3'd2,
        ST_OVER  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   pos_q, pos_d;
    logic            dir_q, dir_d, dir_eff;
    logic [7:0]      score_l_q, score_l_d, score_r_q, score_r_d;
    logic [7:0]      target_q, target_d;
    logic [1:0]      winner_q, winner_d;
    logic            lock_l_q, lock_l_d, lock_r_q, lock_r_d;
    logic [PSW-1:0]  pause_q, pause_d;
    logic [CW-1:0]   presc_q, presc_d;
    logic [31:0]     period;
    logic            tick;
`ifdef PONG_SPEEDUP_EN
    logic [1:0]      level_q, level_d;
    logic            ret;
`endif

    // Input synchronisers: bit 5 start (level only), bits 4..0 edge-detected
    // {inc, dec, clr, paddle_l, paddle_r}.
    logic [5:0] sync1_q, sync2_q;
    logic [4:0] prev_q, rise;
    logic       start_lvl, inc_rise, dec_rise, clr_rise, pl_rise, pr_rise;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= {btn_start, btn_inc, btn_dec, btn_clr, paddle_l, paddle_r};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q[4:0];
        end
    end

    assign rise      = sync2_q[4:0] & ~prev_q;
    assign start_lvl = sync2_q[5];
    assign inc_rise  = rise[4];
    assign dec_rise  = rise[3];
    assign clr_rise  = rise[2];
    assign pl_rise   = rise[1];
    assign pr_rise   = rise[0];

    // Step period; >= compare keeps the tick sane if the period shrinks mid-count.
    always_comb begin
`ifdef PONG_SPEEDUP_EN
        period = 32'(TICK_DIV) >> level_q;
        if (period == 32'd0) begin
            period = 32'd1;
        end
`else
        period = 32'(TICK_DIV);
`endif
        tick = (presc_q >= CW'(period - 32'd1));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_MENU;
            pos_q     <= POS_MID;
            dir_q     <= DIR_L;
            score_l_q <= '0;
            score_r_q <= '0;
            target_q  <= TGT_DEF;
            winner_q  <= '0;
            lock_l_q  <= 1'b0;
            lock_r_q  <= 1'b0;
            pause_q   <= '0;
            presc_q   <= '0;
`ifdef PONG_SPEEDUP_EN
            level_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            dir_q     <= dir_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            target_q  <= target_d;
            winner_q  <= winner_d;
            lock_l_q  <= lock_l_d;
            lock_r_q  <= lock_r_d;
            pause_q   <= pause_d;
            presc_q   <= presc_d;
`ifdef PONG_SPEEDUP_EN
            level_q   <= level_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        dir_d     = dir_q;
        dir_eff   = dir_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        target_d  = target_q;
        winner_d  = winner_q;
        lock_l_d  = lock_l_q;
        lock_r_d  = lock_r_q;
        pause_d   = pause_q;
`ifdef PONG_SPEEDUP_EN
        ret       = 1'b0;
`endif

        case (state_q)
            ST_MENU: begin
                if (start_lvl) begin
                    if (target_q == 8'd0) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d   = ST_RALLY;
                        score_l_d = '0;
                        score_r_d = '0;
                        pos_d     = POS_MID;
                        dir_d     = DIR_L;
                        lock_l_d  = 1'b0;
                        lock_r_d  = 1'b0;
                    end
                end else if (inc_rise && !dec_rise) begin
                    if (target_q < TGT_MAX) target_d = target_q + 8'd1;
                end else if (dec_rise && !inc_rise) begin
                    if (target_q != 8'd0) target_d = target_q - 8'd1;
                end
            end

            ST_RALLY: begin
                // Both paddles judged against the pre-press direction; only the
                // paddle the ball is heading toward can return it.
                if (pr_rise) begin
                    if (dir_q == DIR_R && pos_q != '0 && pos_q <= POS_HIT_R_HI && !lock_r_q) begin
                        dir_eff = DIR_L;
`ifdef PONG_SPEEDUP_EN
                        ret     = 1'b1;
`endif
                    end else begin
                        lock_r_d = 1'b1;
                    end
                end
                if (pl_rise) begin
                    if (dir_q == DIR_L && pos_q >= POS_HIT_L_LO && pos_q <= POS_HIT_L_HI && !lock_l_q) begin
                        dir_eff = DIR_R;
`ifdef PONG_SPEEDUP_EN
                        ret     = 1'b1;
`endif
                    end else begin
                        lock_l_d = 1'b1;
                    end
                end
                dir_d = dir_eff;

                if (tick) begin
                    if (pos_q == '0 && dir_eff == DIR_R) begin
                        score_l_d = score_l_q + 8'd1;
                        lock_l_d  = 1'b0;
                        lock_r_d  = 1'b0;
                        pause_d   = '0;
                        if (score_l_q + 8'd1 == target_q) begin
                            state_d  = ST_OVER;
                            winner_d = 2'b10;
                        end else begin
                            state_d  = ST_POINT;
                        end
                    end else if (pos_q == POS_END_L && dir_eff == DIR_L) begin
                        score_r_d = score_r_q + 8'd1;
                        lock_l_d  = 1'b0;
                        lock_r_d  = 1'b0;
                        pause_d   = '0;
                        if (score_r_q + 8'd1 == target_q) begin
                            state_d  = ST_OVER;
                            winner_d = 2'b01;
                        end else begin
                            state_d  = ST_POINT;
                        end
                    end else if (dir_eff == DIR_L) begin
                        pos_d = pos_q + PW'(1);
                    end else begin
                        pos_d = pos_q - PW'(1);
                    end
                end
            end

            ST_POINT: begin
                // Ball sits on the end it fell off; that end tells who scored,
                // and the serve heads toward the scorer.
                if (tick) begin
                    if (pause_q >= PAUSE_LAST) begin
                        state_d = ST_RALLY;
                        pos_d   = POS_MID;
                        dir_d   = (pos_q == '0) ? DIR_L : DIR_R;
                    end else begin
                        pause_d = pause_q + PSW'(1);
                    end
                end
            end

            ST_OVER: begin
                if (clr_rise) begin
                    state_d   = ST_MENU;
                    score_l_d = '0;
                    score_r_d = '0;
                    winner_d  = '0;
                end
            end

            ST_ERROR: begin
                if (clr_rise) begin
                    state_d  = ST_MENU;
                    target_d = TGT_DEF;
                end
            end

            default: state_d = ST_MENU;
        endcase

        // Prescaler restarts on every state entry so each state gets full ticks.
        if (state_d != state_q || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + CW'(1);
        end

`ifdef PONG_SPEEDUP_EN
        level_d = level_q;
        if (ret && level_q != 2'd3) level_d = level_q + 2'd1;
        if (state_d != state_q) level_d = '0;
`endif
    end

    always_comb begin
        led = '0;
        if (state_q == ST_RALLY || state_q == ST_POINT) begin
            led[pos_q] = 1'b1;
        end
    end

    assign score_l = score_l_q;
    assign score_r = score_r_q;
    assign target  = target_q;
    assign state   = state_q;
    assign winner  = winner_q;

endmodule

// File: tb/tb_pong_engine.sv
// tb_pong_engine: directed game scenarios for pong_engine with a change-driven scoreboard.
// Latency: each observed output change is matched against the next queued expectation, optionally with its cycle gap.
// Backpressure: none; stimulus bounds every wait on the DUT with a cycle budget.
module tb_pong_engine;

    localparam int N = 16;

    localparam logic [5:0] M_START = 6'b100000;
    localparam logic [5:0] M_INC   = 6'b010000;
    localparam logic [5:0] M_DEC   = 6'b001000;
    localparam logic [5:0] M_CLR   = 6'b000100;
    localparam logic [5:0] M_PL    = 6'b000010;
    localparam logic [5:0] M_PR    = 6'b000001;

    logic         clk = 1'b0;
    logic         resetn;
    logic         btn_start, btn_inc, btn_dec, btn_clr, paddle_l, paddle_r;
    logic [N-1:0] led;
    logic [7:0]   score_l, score_r, target;
    logic [2:0]   state;
    logic [1:0]   winner;

    pong_engine #(
        .N_LEDS     (N),
        .TICK_DIV   (4),
        .HIT_WIN    (1),
        .DEF_TARGET (5),
        .MAX_TARGET (20),
        .PAUSE_TICKS(2)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .btn_start(btn_start),
        .btn_inc  (btn_inc),
        .btn_dec  (btn_dec),
        .btn_clr  (btn_clr),
        .paddle_l (paddle_l),
        .paddle_r (paddle_r),
        .led      (led),
        .score_l  (score_l),
        .score_r  (score_r),
        .target   (target),
        .state    (state),
        .winner   (winner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] led;
        logic [2:0]   st;
        logic [7:0]   sl;
        logic [7:0]   sr;
        logic [7:0]   tg;
        logic [1:0]   win;
        int           gap;   // cycles since previous change, 0 = not checked
    } obs_t;

    obs_t  exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    logic  mon_en = 1'b0;

    function automatic logic [N-1:0] b(input int p);
        logic [N-1:0] one;
        one = 1;
        return one << p;
    endfunction

    task automatic push(input logic [N-1:0] l, input logic [2:0] st, input logic [7:0] sl,
                        input logic [7:0] sr, input logic [7:0] tg, input logic [1:0] win, input int gap);
        obs_t e;
        e.led = l; e.st = st; e.sl = sl; e.sr = sr; e.tg = tg; e.win = win; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [5:0] m);
        {btn_start, btn_inc, btn_dec, btn_clr, paddle_l, paddle_r} = m;
        cyc_wait(3);
        {btn_start, btn_inc, btn_dec, btn_clr, paddle_l, paddle_r} = 6'b0;
        cyc_wait(3);
    endtask

    task automatic wait_led(input logic [N-1:0] want);
        int k;
        k = 0;
        while (led !== want && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (led !== want) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_led timeout: led=%h required %h", led, want);
        end
    endtask

    task automatic wait_state(input logic [2:0] want);
        int k;
        k = 0;
        while (state !== want && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (state !== want) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_state timeout: state=%0d required %0d", state, want);
        end
    endtask

    // Monitor: any change of the visible tuple is an output event.
    logic [44:0] last_obs = '1;
    int          cyc = 0;
    int          last_cyc = 0;
    int          idx = 0;

    initial begin
        logic [44:0] cur;
        obs_t        e;
        int          gap;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en) begin
                cur = {led, state, score_l, score_r, target, winner};
                if (cur != last_obs) begin
                    gap = cyc - last_cyc;
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_change[%0d]: led=%h st=%0d l=%0d r=%0d tgt=%0d win=%b, required no change",
                                 idx, led, state, score_l, score_r, target, winner);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.led !== led || e.st !== state || e.sl !== score_l || e.sr !== score_r ||
                            e.tg !== target || e.win !== winner || (e.gap != 0 && e.gap != gap)) begin
                            n_err++;
                            $display("FAIL trace[%0d]: got led=%h st=%0d l=%0d r=%0d tgt=%0d win=%b gap=%0d, required led=%h st=%0d l=%0d r=%0d tgt=%0d win=%b gap=%0d",
                                     idx, led, state, score_l, score_r, target, winner, gap,
                                     e.led, e.st, e.sl, e.sr, e.tg, e.win, e.gap);
                        end
                    end
                    idx++;
                    last_obs = cur;
                    last_cyc = cyc;
                end
            end
        end
    end

    initial begin
        {btn_start, btn_inc, btn_dec, btn_clr, paddle_l, paddle_r} = 6'b0;
        resetn = 1'b1;
        #3 resetn = 1'b0;
        push('0, 0, 0, 0, 5, 0, 0);
        mon_en = 1'b1;
        cyc_wait(3);
        #2 resetn = 1'b1;
        cyc_wait(2);

        // Menu: dec to 0, start -> ERROR, clr -> MENU with default target
        for (int t = 4; t >= 0; t--) push('0, 0, 0, 0, 8'(t), 0, 0);
        repeat (5) pulse(M_DEC);
        push('0, 4, 0, 0, 0, 0, 0);
        pulse(M_START);
        push('0, 0, 0, 0, 5, 0, 0);
        pulse(M_CLR);

        // inc saturates at 20; inc+dec together changes nothing
        for (int t = 6; t <= 20; t++) push('0, 0, 0, 0, 8'(t), 0, 0);
        repeat (20) pulse(M_INC);
        pulse(M_INC | M_DEC);

        // Rally: miss on the left, serve toward scorer, right return,
        // left return, right lockout, left scores, reset mid-rally.
        push(b(8), 1, 0, 0, 20, 0, 0);
        for (int p = 9; p <= 15; p++) push(b(p), 1, 0, 0, 20, 0, 4);
        push(b(15), 2, 0, 1, 20, 0, 4);
        push(b(8), 1, 0, 1, 20, 0, 8);
        for (int p = 7; p >= 1; p--) push(b(p), 1, 0, 1, 20, 0, 4);
        for (int p = 2; p <= 14; p++) push(b(p), 1, 0, 1, 20, 0, 4);
        for (int p = 13; p >= 0; p--) push(b(p), 1, 0, 1, 20, 0, 4);
        push(b(0), 2, 1, 1, 20, 0, 4);
        push(b(8), 1, 1, 1, 20, 0, 8);
        push(b(9), 1, 1, 1, 20, 0, 4);
        pulse(M_START);
        wait_led(b(1));
        pulse(M_PR);
        wait_led(b(14));
        pulse(M_PL);
        wait_led(b(5));
        pulse(M_PR);
        wait_led(b(1));
        pulse(M_PR);
        wait_led(b(9));
        push('0, 0, 0, 0, 5, 0, 0);
        #2 resetn = 1'b0;
        cyc_wait(3);
        #2 resetn = 1'b1;
        cyc_wait(2);

        // target 1: left misses -> OVER, winner right; clr keeps target
        for (int t = 4; t >= 1; t--) push('0, 0, 0, 0, 8'(t), 0, 0);
        repeat (4) pulse(M_DEC);
        push(b(8), 1, 0, 0, 1, 0, 0);
        for (int p = 9; p <= 15; p++) push(b(p), 1, 0, 0, 1, 0, 4);
        push('0, 3, 0, 1, 1, 2'b01, 4);
        pulse(M_START);
        wait_state(3);
        push('0, 0, 0, 0, 1, 0, 0);
        pulse(M_CLR);
        cyc_wait(20);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL trace_drained: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
